// File: rtl/multi_debounce_pkg.sv
// Shared debounce definitions.
// Holds the default parameter values used by multi_debounce and its
// per-channel sub-module, plus the counter width helper.
package multi_debounce_pkg;

    localparam int DEF_CHANNELS      = 4;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 16;
    localparam int DEF_HOLD_CYCLES   = 1000;
    localparam int DEF_REPEAT_CYCLES = 0;

    // One spare bit above $clog2 so a counter can always hold its
    // terminal value without wrapping.
    function automatic int cnt_width(int value);
        return $clog2(value) + 1;
    endfunction

endpackage

// File: rtl/multi_debounce_chan.sv
// One debounce channel: synchroniser chain, stability counter, edge
// pulses and long-press / auto-repeat pulse generation.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   button     raw asynchronous input bit
//   debounced  accepted level
//   rise       one-cycle pulse on accepted 0->1
//   fall       one-cycle pulse on accepted 1->0
//   hold       one-cycle long-press / auto-repeat pulse
module multi_debounce_chan
    import multi_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic debounced,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam int  SW        = cnt_width(STABLE_CYCLES);
    localparam int  HOLD_MAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int  HW        = cnt_width(HOLD_MAX);
    localparam bit  REPEAT_EN = (REPEAT_CYCLES > 0);
    localparam int  REP_TGT   = REPEAT_EN ? REPEAT_CYCLES - 1 : 0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [SW-1:0]          stab_cnt;
    logic [HW-1:0]          hold_cnt;
    logic                   rep_phase;   // first hold pulse already emitted

    logic          differs;
    logic          accept;
    logic [HW-1:0] hold_target;
    logic          hold_hit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        differs     = sync_bit ^ debounced;
        accept      = differs && (stab_cnt == SW'(STABLE_CYCLES - 1));
        hold_target = rep_phase ? HW'(REP_TGT) : HW'(HOLD_CYCLES - 1);
        // A falling accept on this edge cancels the hold pulse; with repeat
        // disabled the counter is parked after the first pulse.
        hold_hit    = debounced && !accept && !(rep_phase && !REPEAT_EN)
                      && (hold_cnt == hold_target);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            stab_cnt  <= '0;
            debounced <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            hold      <= 1'b0;
            hold_cnt  <= '0;
            rep_phase <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button};

            if (!differs || accept) begin
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end

            if (accept) begin
                debounced <= sync_bit;
            end
            rise <= accept && sync_bit;
            fall <= accept && !sync_bit;
            hold <= hold_hit;

            if (!debounced || accept) begin
                hold_cnt  <= '0;
                rep_phase <= 1'b0;
            end else if (hold_hit) begin
                hold_cnt  <= '0;
                rep_phase <= 1'b1;
            end else if (hold_cnt != hold_target) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_debounce.sv
// Multi-channel button debouncer. Each bit of button is handled by an
// independent multi_debounce_chan instance.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   button     raw asynchronous inputs, bit i = channel i
//   debounced  accepted level per channel
//   rise       one-cycle pulse per channel on accepted 0->1
//   fall       one-cycle pulse per channel on accepted 1->0
//   hold       one-cycle long-press / auto-repeat pulse per channel
module multi_debounce
    import multi_debounce_pkg::*;
#(
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        multi_debounce_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .button   (button[i]),
            .debounced(debounced[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .hold     (hold[i])
        );
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce. Stimulus pushes the expected pulse
// events (cycle, rise, fall, hold, debounced) into per-DUT queues; a
// monitor pops and compares whenever a DUT shows any pulse.
module tb_multi_debounce;

    localparam int CH = 2;
    localparam int W  = 32 + 4 * CH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] btn_a, deb_a, rise_a, fall_a, hold_a;
    logic [CH-1:0] btn_b, deb_b, rise_b, fall_b, hold_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_debounce #(
        .CHANNELS(CH), .SYNC_STAGES(2), .STABLE_CYCLES(4),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(5)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .button(btn_a),
        .debounced(deb_a), .rise(rise_a), .fall(fall_a), .hold(hold_a)
    );

    multi_debounce #(
        .CHANNELS(CH), .SYNC_STAGES(2), .STABLE_CYCLES(4),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .button(btn_b),
        .debounced(deb_b), .rise(rise_b), .fall(fall_b), .hold(hold_b)
    );

    // Driver tasks
    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input int c, input logic [CH-1:0] r, input logic [CH-1:0] f,
                          input logic [CH-1:0] h, input logic [CH-1:0] d);
        exp_a.push_back({c[31:0], r, f, h, d});
    endtask

    task automatic push_b(input int c, input logic [CH-1:0] r, input logic [CH-1:0] f,
                          input logic [CH-1:0] h, input logic [CH-1:0] d);
        exp_b.push_back({c[31:0], r, f, h, d});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] act, req;
        if ((|rise_a) || (|fall_a) || (|hold_a)) begin
            act = {cyc[31:0], rise_a, fall_a, hold_a, deb_a};
            n_checks++;
            if (exp_a.size() == 0) begin
                n_fail++;
                $display("FAIL dut_a unexpected event: got %0h expected none", act);
            end else begin
                req = exp_a.pop_front();
                if (act !== req) begin
                    n_fail++;
                    $display("FAIL dut_a event: got %0h expected %0h", act, req);
                end
            end
        end
        if ((|rise_b) || (|fall_b) || (|hold_b)) begin
            act = {cyc[31:0], rise_b, fall_b, hold_b, deb_b};
            n_checks++;
            if (exp_b.size() == 0) begin
                n_fail++;
                $display("FAIL dut_b unexpected event: got %0h expected none", act);
            end else begin
                req = exp_b.pop_front();
                if (act !== req) begin
                    n_fail++;
                    $display("FAIL dut_b event: got %0h expected %0h", act, req);
                end
            end
        end
    end

    initial begin
        int c0, c1;
        rst_n = 1'b0;
        btn_a = '0;
        btn_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_deb_a",  32'(deb_a),  32'd0);
        check("reset_rise_a", 32'(rise_a), 32'd0);
        check("reset_fall_a", 32'(fall_a), 32'd0);
        check("reset_hold_a", 32'(hold_a), 32'd0);
        check("reset_deb_b",  32'(deb_b),  32'd0);
        rst_n = 1'b1;
        goto(cyc + 3);

        // Clean press on channel 0, released before any hold
        c0 = cyc;
        btn_a[0] = 1'b1;
        push_a(c0 + 6, 2'b01, 2'b00, 2'b00, 2'b01);
        goto(c0 + 5);
        check("press_not_early", 32'(deb_a), 32'd0);
        goto(c0 + 7);
        check("rise_one_cycle", 32'(rise_a), 32'd0);
        check("press_deb", 32'(deb_a), 32'd1);
        goto(c0 + 8);
        btn_a[0] = 1'b0;
        push_a(c0 + 14, 2'b00, 2'b01, 2'b00, 2'b00);
        goto(c0 + 30);

        // Three-cycle pulse is rejected
        c0 = cyc;
        btn_a[0] = 1'b1;
        goto(c0 + 3);
        btn_a[0] = 1'b0;
        goto(c0 + 15);
        check("glitch_deb", 32'(deb_a), 32'd0);

        // Long press with auto-repeat on channel 1; fall lands on a
        // would-be repeat edge and suppresses it
        c0 = cyc;
        btn_a[1] = 1'b1;
        push_a(c0 + 6,  2'b10, 2'b00, 2'b00, 2'b10);
        push_a(c0 + 16, 2'b00, 2'b00, 2'b10, 2'b10);
        push_a(c0 + 21, 2'b00, 2'b00, 2'b10, 2'b10);
        push_a(c0 + 26, 2'b00, 2'b00, 2'b10, 2'b10);
        goto(c0 + 25);
        btn_a[1] = 1'b0;
        push_a(c0 + 31, 2'b00, 2'b10, 2'b00, 2'b00);
        goto(c0 + 50);

        // Both channels on the same edge
        c0 = cyc;
        btn_a = 2'b11;
        push_a(c0 + 6, 2'b11, 2'b00, 2'b00, 2'b11);
        goto(c0 + 7);
        btn_a = 2'b00;
        push_a(c0 + 13, 2'b00, 2'b11, 2'b00, 2'b00);
        goto(c0 + 30);

        // Reset mid-debounce (ch0) and mid-hold (ch1)
        c0 = cyc;
        btn_a[1] = 1'b1;
        push_a(c0 + 6, 2'b10, 2'b00, 2'b00, 2'b10);
        goto(c0 + 8);
        btn_a[0] = 1'b1;
        goto(c0 + 10);
        check("pre_reset_deb", 32'(deb_a), 32'd2);
        rst_n = 1'b0;
        #1;
        check("async_reset_deb",  32'(deb_a),  32'd0);
        check("async_reset_rise", 32'(rise_a), 32'd0);
        check("async_reset_fall", 32'(fall_a), 32'd0);
        check("async_reset_hold", 32'(hold_a), 32'd0);
        goto(c0 + 13);
        rst_n = 1'b1;
        c1 = cyc;
        push_a(c1 + 6, 2'b11, 2'b00, 2'b00, 2'b11);
        goto(c1 + 7);
        btn_a = 2'b00;
        push_a(c1 + 13, 2'b00, 2'b11, 2'b00, 2'b00);
        goto(c1 + 30);

        // Repeat disabled: one hold pulse only over a 40-cycle press
        c0 = cyc;
        btn_b[0] = 1'b1;
        push_b(c0 + 6,  2'b01, 2'b00, 2'b00, 2'b01);
        push_b(c0 + 16, 2'b00, 2'b00, 2'b01, 2'b01);
        goto(c0 + 40);
        check("norepeat_deb", 32'(deb_b), 32'd1);
        btn_b[0] = 1'b0;
        push_b(c0 + 46, 2'b00, 2'b01, 2'b00, 2'b00);
        goto(c0 + 60);

        // Final report
        check("exp_a_drained", 32'(exp_a.size()), 32'd0);
        check("exp_b_drained", 32'(exp_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent button/input channels, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, 2..4.
REQ-003 Parameter STABLE_CYCLES, default 16: consecutive cycles of disagreement required to accept a new level, >=1.
REQ-004 Parameter HOLD_CYCLES, default 1000: cycles of accepted-high before the first hold pulse, >=1.
REQ-005 Parameter REPEAT_CYCLES, default 0: auto-repeat period after the first hold pulse; 0 disables repeat.
REQ-006 clk  input  1  single clock; all state is clocked on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset; one clock, and reset is asynchronous and active-low.
REQ-008 button  input  CHANNELS  raw asynchronous inputs, bit i = channel i.
REQ-009 debounced  output  CHANNELS  accepted level per channel.
REQ-010 rise  output  CHANNELS  one-cycle pulse when debounced[i] goes 0->1.
REQ-011 fall  output  CHANNELS  one-cycle pulse when debounced[i] goes 1->0.
REQ-012 hold  output  CHANNELS  one-cycle long-press / auto-repeat pulse.

Function
REQ-013 Each channel passes button[i] through SYNC_STAGES flops; the last stage is sync[i].
REQ-014 Stability counter: sync[i] == debounced[i] -> counter cleared to 0; otherwise counter increments.
REQ-015 On the clock edge where the counter equals STABLE_CYCLES-1 and sync[i] still differs, debounced[i] takes sync[i] and the counter clears.
REQ-016 A single-cycle glitch, or any disagreement run shorter than STABLE_CYCLES cycles, leaves debounced[i] unchanged and clears the counter.
REQ-017 Latency from a clean button edge to the debounced change: exactly SYNC_STAGES+STABLE_CYCLES clock edges.
REQ-018 rise[i] or fall[i] is registered on the same edge that debounced[i] changes and is high for exactly one cycle; rise and fall are never both high.
REQ-019 Hold counter: cleared while debounced[i]==0; increments while debounced[i]==1.
REQ-020 First hold[i] pulse occurs HOLD_CYCLES edges after rise[i].
REQ-021 With REPEAT_CYCLES>0, further hold[i] pulses follow every REPEAT_CYCLES edges while high; with REPEAT_CYCLES==0, the counter saturates and no further pulses occur.
REQ-022 A release (fall[i]) cancels any pending hold; a hold pulse never coincides with fall.
REQ-023 Counter widths: $clog2 of the parameter +1; no wrap-around is permitted.
REQ-024 Channels are fully independent; simultaneous events on several channels produce simultaneous pulses.

Reset
REQ-025 Asserting reset asynchronously clears synchroniser flops, counters, debounced, rise, fall and hold to 0.
REQ-026 Reset mid-debounce or mid-hold aborts the operation with no pulse emitted.
REQ-027 After release, an input held high is treated as a new press and yields rise after the REQ-017 latency.

Structure
REQ-028 Shared header debounce_defs holds default parameter values and the $clog2-based width helper.
REQ-029 One sub-module, debounce_chan (synchroniser, stability counter, edge/hold logic for one bit), is instantiated CHANNELS times via generate.

Verification (CHANNELS=2, SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5)
REQ-030 button[0] 0->1 clean at edge 0 -> debounced[0]=1 and rise[0]=1 at edge 6, rise low at edge 7.
REQ-031 button[0] high for 3 cycles, then low -> debounced, rise and fall stay 0 throughout.
REQ-032 button[1] held high -> hold[1] pulses 10, 15 and 20 edges after rise[1]; release -> fall[1] and no further hold.
REQ-033 Both channels toggled on the same edge -> rise[0] and rise[1] high on the same cycle.
REQ-034 reset asserted 2 cycles into a debounce -> all outputs 0 immediately; after release with button still high, rise occurs 6 edges later.
REQ-035 REPEAT_CYCLES=0 build, button held 40 cycles -> exactly one hold pulse.
